slab_test_sequencer: RTL and testbench
======================================

Name: slab_test_sequencer

Overview:
- Runs the full ray/AABB slab test through one shared greater_than comparator instead of eight parallel comparators.
- Accepts six slab-entry/exit distances (x0,x1,y0,y1,z0,z1) in the team's 16-bit FloPoCo word: bits [15:14] are the exception field, bit [13] is the sign, bits [12:0] are exponent and fraction.
- Schedules eight dependent comparisons and returns tmin, tmax and hit.
- Sits between the per-axis t-computation stage and the hit-record logic.

Parameters:
- WIDTH, 15, MSB index of an operand word; word is WIDTH+1 bits.
- CMP_LAT, 3, clocks from a change on the comparator inputs to a valid greater output. This is FPSub pipeline depth + 1 output register, and it must match the instanced core.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  six distances valid
- in_ready  out  1  block idle, can accept
- tx0, tx1, ty0, ty1, tz0, tz1  in  WIDTH+1 each  slab distances
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- tmin  out  WIDTH+1  max of per-axis near values
- tmax  out  WIDTH+1  min of per-axis far values
- hit  out  1  1 iff tmax > tmin per comparator semantics

Behaviour:
- Reset (rst=0, async): state=IDLE, step=0, wait counter=0, all working regs=0. Outputs: in_ready=0 while in reset, out_valid=0, tmin=0, tmax=0, hit=0.
- greater_than is instanced with rst = ~rst, because its reset is active-high.
- A reset mid-operation discards the job; after reset release the block is IDLE and in_ready=1.
- Comparator semantics: g=1 only if inA-inB is normal and positive (exc=01, sign=0).
  - Equal operands give g=0.
  - Any inf/NaN difference gives g=0, i.e. "not greater"; the block does no special-casing.
- FSM states: IDLE, CMP, CAPT, DONE.
  - IDLE: in_ready=1. On in_valid, latch the six inputs, set step=0, go to CMP.
  - CMP: comparator operands are muxed from working regs by step, and stay stable for the whole CMP phase. Wait counter runs 0..CMP_LAT-1; at CMP_LAT-1 go to CAPT.
  - CAPT: sample g and update working regs for the step. If step==7, go to DONE; else step+1 and go to CMP.
  - DONE: out_valid=1, outputs held. On out_ready, go to IDLE (out_valid drops the next cycle). in_ready=1 is first asserted in the cycle after the handshake, so there is no back-to-back accept.
- Step schedule, with g = (A>B):
  - 0: A=x0, B=x1. nx = g?x1:x0, fx = g?x0:x1.
  - 1: same for y, giving ny, fy.
  - 2: same for z, giving nz, fz.
  - 3: A=nx, B=ny. nm = g?nx:ny.
  - 4: A=nm, B=nz. tmin = g?nm:nz.
  - 5: A=fx, B=fy. fm = g?fy:fx.
  - 6: A=fm, B=fz. tmax = g?fz:fm.
  - 7: A=tmax, B=tmin. hit = g.
- Latency:
  - Each step takes CMP_LAT+1 cycles.
  - out_valid rises 8*(CMP_LAT+1) edges after the accepting edge (32 at default).
  - Throughput is one job per 8*(CMP_LAT+1)+2 cycles minimum.
- Inputs are ignored outside IDLE. tmin, tmax and hit change only in CAPT and are stable throughout DONE.
- Simultaneous out_ready and in_valid in DONE: the result is taken and the input is not accepted.

Decomposition:
- Shared package (slab_pkg):
  - FSM state encoding.
  - Step constants 0..7.
  - Field positions EXC_HI=WIDTH, EXC_LO=WIDTH-1, SIGN=WIDTH-2.
  - EXC_NORMAL=2'b01.
- One sub-module: the existing greater_than, instanced once. The step mux and writeback stay in slab_test_sequencer.

Test Plan:
- Ordered box: x0=1.0, x1=4.0, y0=2.0, y1=5.0, z0=0.5, z1=3.0 -> tmin=2.0, tmax=3.0, hit=1; out_valid exactly 32 edges after accept.
- Swapped axes: x0=4.0, x1=1.0, y0=5.0, y1=2.0, z0=3.0, z1=0.5 -> same result (tmin=2.0, tmax=3.0, hit=1).
- Miss: x0=1.0, x1=2.0, y0=3.0, y1=4.0, z0=0.0, z1=5.0 -> tmin=3.0, tmax=2.0, hit=0.
- Touching/equal: all six inputs 2.0 -> tmin=2.0, tmax=2.0, hit=0 (equal is not greater).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, tmin, tmax and hit stable and in_ready=0; in_valid pulses during this time are ignored.
- Reset mid-job: drop rst at step 4 -> out_valid=0 and in_ready=0 immediately; after release in_ready=1, and a new job produces the correct result with no residue from the aborted one.

Source files
------------

// File: rtl/slab_pkg.sv
// rtl/slab_pkg.sv - shared states, step codes, FloPoCo field positions and operand decode
package slab_pkg;

  // Operand word is SLAB_WIDTH+1 bits: [15:14] exception, [13] sign, [12:0] exponent/fraction
  localparam int SLAB_WIDTH = 15;
  localparam int EXC_HI     = SLAB_WIDTH;
  localparam int EXC_LO     = SLAB_WIDTH - 1;
  localparam int SIGN       = SLAB_WIDTH - 2;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One code per dependent comparison, in issue order
  typedef enum logic [2:0] {
    STEP_X       = 3'd0,
    STEP_Y       = 3'd1,
    STEP_Z       = 3'd2,
    STEP_NEAR_XY = 3'd3,
    STEP_NEAR_Z  = 3'd4,
    STEP_FAR_XY  = 3'd5,
    STEP_FAR_Z   = 3'd6,
    STEP_HIT     = 3'd7
  } step_e;

  // First comparator stage: operand classification plus raw magnitudes
  typedef struct packed {
    logic            never;
    logic            a_norm;
    logic            b_norm;
    logic            sa;
    logic            sb;
    logic [SIGN-1:0] ma;
    logic [SIGN-1:0] mb;
  } cmp_dec_t;

  // An inf/NaN operand makes the difference inf/NaN, and 0-0 is zero: neither is "greater"
  function automatic cmp_dec_t decode_pair(logic [SLAB_WIDTH:0] a, logic [SLAB_WIDTH:0] b);
    cmp_dec_t d;
    d.never  = a[EXC_HI] | b[EXC_HI] |
               ((a[EXC_HI:EXC_LO] == EXC_ZERO) & (b[EXC_HI:EXC_LO] == EXC_ZERO));
    d.a_norm = (a[EXC_HI:EXC_LO] == EXC_NORMAL);
    d.b_norm = (b[EXC_HI:EXC_LO] == EXC_NORMAL);
    d.sa     = a[SIGN];
    d.sb     = b[SIGN];
    d.ma     = a[SIGN-1:0];
    d.mb     = b[SIGN-1:0];
    return d;
  endfunction

endpackage

// File: rtl/greater_than.sv
// rtl/greater_than.sv - pipelined FloPoCo greater-than: 1 iff inA-inB is a positive normal
module greater_than
  import slab_pkg::*;
#(
  parameter int WIDTH = SLAB_WIDTH,
  parameter int LAT   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [WIDTH:0] inA,
  input  logic [WIDTH:0] inB,
  output logic         greater
);

  cmp_dec_t         dec_q;
  logic             g_d;
  logic [LAT-2:0]   pipe_q;

  // Stage 1: classify both operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= '0;
    end else begin
      dec_q <= decode_pair(inA, inB);
    end
  end

  // Sign of the difference; exponent/fraction compare as one unsigned magnitude
  always_comb begin
    g_d = 1'b0;
    if (dec_q.never) begin
      g_d = 1'b0;
    end else if (dec_q.a_norm && !dec_q.b_norm) begin
      g_d = ~dec_q.sa;
    end else if (!dec_q.a_norm && dec_q.b_norm) begin
      g_d = dec_q.sb;
    end else if (dec_q.sa != dec_q.sb) begin
      g_d = ~dec_q.sa;
    end else if (!dec_q.sa) begin
      g_d = (dec_q.ma > dec_q.mb);
    end else begin
      g_d = (dec_q.ma < dec_q.mb);
    end
  end

  // Remaining stages: result plus delay up to the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= g_d;
      for (int i = 1; i <= LAT - 2; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign greater = pipe_q[LAT-2];

endmodule

// File: rtl/slab_test_sequencer.sv
// rtl/slab_test_sequencer.sv - ray/AABB slab test scheduled over one shared comparator
module slab_test_sequencer
  import slab_pkg::*;
#(
  parameter int WIDTH   = SLAB_WIDTH,
  parameter int CMP_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] tx0,
  input  logic [WIDTH:0] tx1,
  input  logic [WIDTH:0] ty0,
  input  logic [WIDTH:0] ty1,
  input  logic [WIDTH:0] tz0,
  input  logic [WIDTH:0] tz1,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] tmin,
  output logic [WIDTH:0] tmax,
  output logic           hit
);

  localparam int WAIT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CMP_LAT - 1);

  state_e            state_q, state_d;
  step_e             step_q, step_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              latch_en, capt_en;

  logic [WIDTH:0] x0_q, x1_q, y0_q, y1_q, z0_q, z1_q;
  logic [WIDTH:0] nx_q, fx_q, ny_q, fy_q, nz_q, fz_q, nm_q, fm_q;
  logic [WIDTH:0] tmin_q, tmax_q;
  logic           hit_q;

  logic [WIDTH:0] cmp_a, cmp_b;
  logic           cmp_g;
  logic           cmp_rst;

  // Comparator core resets active-high
  assign cmp_rst = ~rst;

  greater_than #(
    .WIDTH (WIDTH),
    .LAT   (CMP_LAT)
  ) u_greater_than (
    .clk     (clk),
    .rst     (cmp_rst),
    .inA     (cmp_a),
    .inB     (cmp_b),
    .greater (cmp_g)
  );

  // Control state: FSM, step index and comparator wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_X;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
    end
  end

  // Next state: wait out the comparator latency, then capture once per step
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    wait_d   = wait_q;
    latch_en = 1'b0;
    capt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          latch_en = 1'b1;
          step_d   = STEP_X;
          wait_d   = '0;
          state_d  = ST_CMP;
        end
      end
      ST_CMP: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_CAPT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_CAPT: begin
        capt_en = 1'b1;
        if (step_q == STEP_HIT) begin
          state_d = ST_DONE;
        end else begin
          step_d  = step_e'(step_q + 3'd1);
          state_d = ST_CMP;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand select; step and working regs only change at CAPT so operands hold through CMP
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    case (step_q)
      STEP_X:       begin cmp_a = x0_q;   cmp_b = x1_q;   end
      STEP_Y:       begin cmp_a = y0_q;   cmp_b = y1_q;   end
      STEP_Z:       begin cmp_a = z0_q;   cmp_b = z1_q;   end
      STEP_NEAR_XY: begin cmp_a = nx_q;   cmp_b = ny_q;   end
      STEP_NEAR_Z:  begin cmp_a = nm_q;   cmp_b = nz_q;   end
      STEP_FAR_XY:  begin cmp_a = fx_q;   cmp_b = fy_q;   end
      STEP_FAR_Z:   begin cmp_a = fm_q;   cmp_b = fz_q;   end
      STEP_HIT:     begin cmp_a = tmax_q; cmp_b = tmin_q; end
      default:      begin cmp_a = '0;     cmp_b = '0;     end
    endcase
  end

  // Working registers: latch inputs on accept, write back the ordered pair on capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_q   <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0; z0_q <= '0; z1_q <= '0;
      nx_q   <= '0; fx_q <= '0; ny_q <= '0; fy_q <= '0; nz_q <= '0; fz_q <= '0;
      nm_q   <= '0; fm_q <= '0;
      tmin_q <= '0;
      tmax_q <= '0;
      hit_q  <= 1'b0;
    end else if (latch_en) begin
      x0_q <= tx0; x1_q <= tx1;
      y0_q <= ty0; y1_q <= ty1;
      z0_q <= tz0; z1_q <= tz1;
    end else if (capt_en) begin
      case (step_q)
        STEP_X: begin
          nx_q <= cmp_g ? x1_q : x0_q;
          fx_q <= cmp_g ? x0_q : x1_q;
        end
        STEP_Y: begin
          ny_q <= cmp_g ? y1_q : y0_q;
          fy_q <= cmp_g ? y0_q : y1_q;
        end
        STEP_Z: begin
          nz_q <= cmp_g ? z1_q : z0_q;
          fz_q <= cmp_g ? z0_q : z1_q;
        end
        STEP_NEAR_XY: nm_q   <= cmp_g ? nx_q : ny_q;
        STEP_NEAR_Z:  tmin_q <= cmp_g ? nm_q : nz_q;
        STEP_FAR_XY:  fm_q   <= cmp_g ? fy_q : fx_q;
        STEP_FAR_Z:   tmax_q <= cmp_g ? fz_q : fm_q;
        STEP_HIT:     hit_q  <= cmp_g;
        default:      hit_q  <= hit_q;
      endcase
    end
  end

  // Held low throughout reset, not just after it
  assign in_ready  = rst & (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign tmin      = tmin_q;
  assign tmax      = tmax_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_slab_test_sequencer.sv
// tb/tb_slab_test_sequencer.sv - scoreboard bench for slab_test_sequencer
module tb_slab_test_sequencer;

  // FloPoCo words with wE=5 (bias 15), wF=8, exception 01 = normal
  localparam logic [15:0] F0   = 16'h0000;
  localparam logic [15:0] F05  = 16'h4E00;
  localparam logic [15:0] F1   = 16'h4F00;
  localparam logic [15:0] F2   = 16'h5000;
  localparam logic [15:0] F3   = 16'h5080;
  localparam logic [15:0] F4   = 16'h5100;
  localparam logic [15:0] F5   = 16'h5140;
  localparam logic [15:0] FM1  = 16'h6F00;
  localparam logic [15:0] FM2  = 16'h7000;

  typedef struct packed {
    logic [15:0] tmin;
    logic [15:0] tmax;
    logic        hit;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] tx0, tx1, ty0, ty1, tz0, tz1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] tmin, tmax;
  logic        hit;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  slab_test_sequencer #(.WIDTH(15), .CMP_LAT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx0       (tx0),
    .tx1       (tx1),
    .ty0       (ty0),
    .ty1       (ty1),
    .tz0       (tz0),
    .tz1       (tz1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tmin      (tmin),
    .tmax      (tmax),
    .hit       (hit)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: compare against the scoreboard on every result handshake
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tmin", 32'(tmin), 32'(e.tmin));
          check("tmax", 32'(tmax), 32'(e.tmax));
          check("hit",  32'(hit),  32'(e.hit));
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a0, a1, b0, b1, c0, c1,
                       input res_t e, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    tx0 = a0; tx1 = a1; ty0 = b0; ty1 = b1; tz0 = c0; tz1 = c1;
    in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_take", 32'(out_valid), 32'd0);
    check("in_ready_after_take",  32'(in_ready),  32'd1);
  endtask

  task automatic run_job(input logic [15:0] a0, a1, b0, b1, c0, c1, input res_t e,
                         input string name);
    int edges;
    issue(a0, a1, b0, b1, c0, c1, e, 1'b1);
    wait_valid(edges);
    check({name, "_latency"}, 32'(edges), 32'd32);
    take();
  endtask

  initial begin
    int edges;
    res_t e_ord, e_miss, e_eq, e_neg;
    e_ord  = '{tmin: F2,  tmax: F3, hit: 1'b1};
    e_miss = '{tmin: F3,  tmax: F2, hit: 1'b0};
    e_eq   = '{tmin: F2,  tmax: F2, hit: 1'b0};
    e_neg  = '{tmin: F05, tmax: F1, hit: 1'b1};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tx0 = '0; tx1 = '0; ty0 = '0; ty1 = '0; tz0 = '0; tz1 = '0;
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_tmin",      32'(tmin),      32'd0);
    check("reset_tmax",      32'(tmax),      32'd0);
    check("reset_hit",       32'(hit),       32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_job(F1, F4, F2, F5, F05, F3, e_ord,  "ordered");
    run_job(F4, F1, F5, F2, F3, F05, e_ord,  "swapped");
    run_job(F1, F2, F3, F4, F0, F5,  e_miss, "miss");
    run_job(F2, F2, F2, F2, F2, F2,  e_eq,   "equal");
    run_job(FM1, F4, FM2, F1, F05, F3, e_neg, "negative");

    // Backpressure: result held while stray in_valid pulses are ignored
    issue(F1, F2, F3, F4, F0, F5, e_miss, 1'b1);
    wait_valid(edges);
    check("bp_latency", 32'(edges), 32'd32);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      tx0 = F5; tx1 = F5; ty0 = F5; ty1 = F5; tz0 = F5; tz1 = F5;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_hold", {15'd0, tmin, hit}, {15'd0, e_miss.tmin, e_miss.hit});
      check("bp_hold_tmax", 32'(tmax), 32'(e_miss.tmax));
    end
    // Result taken together with a new in_valid: the input is not accepted
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("simul_out_valid", 32'(out_valid), 32'd0);
    check("simul_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    check("simul_still_idle", 32'(in_ready), 32'd1);

    // Reset during step 4 of a job, then a clean job
    issue(F4, F1, F5, F2, F3, F05, e_ord, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd0);
    check("abort_tmin",      32'(tmin),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_release_in_ready", 32'(in_ready), 32'd1);
    run_job(FM1, F4, FM2, F1, F05, F3, e_neg, "after_abort");

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
